// File: rtl/cva6_config_pkg.sv
// Core-wide geometry constants shared by CVA6 blocks.
package cva6_config_pkg;
  localparam int unsigned CVA6ConfigNrScoreboardEntries = 8;
  localparam int unsigned CVA6ConfigNrCommitPorts       = 2;
endpackage

// File: rtl/rob_pkg.sv
// Shared types, defaults and width helpers for the reorder/commit window.
package rob_pkg;
  localparam int unsigned DefNrEntries     = cva6_config_pkg::CVA6ConfigNrScoreboardEntries;
  localparam int unsigned DefNrCommitPorts = cva6_config_pkg::CVA6ConfigNrCommitPorts;
  localparam int unsigned DefNrWbPorts     = 4;
  localparam int unsigned DefXlen          = 64;
  localparam int unsigned DefPayloadWidth  = 64;

  typedef struct packed {
    logic                       valid;
    logic                       done;
    logic [DefPayloadWidth-1:0] payload;
    logic [DefXlen-1:0]         result;
  } rob_entry_t;

  function automatic int unsigned rob_id_width(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction
endpackage

// File: rtl/rob_wb_arbiter.sv
// Folds the writeback ports into per-entry done strobes; lowest port index wins a collision.
module rob_wb_arbiter
  import rob_pkg::*;
#(
  parameter int unsigned NrEntries = DefNrEntries,
  parameter int unsigned NrWbPorts = DefNrWbPorts,
  parameter int unsigned Xlen      = DefXlen,
  localparam int unsigned IdW      = rob_id_width(NrEntries)
) (
  input  logic [NrWbPorts-1:0]           wb_valid,
  input  logic [NrWbPorts-1:0][IdW-1:0]  wb_id,
  input  logic [NrWbPorts-1:0][Xlen-1:0] wb_result,
  input  logic [NrEntries-1:0]           entry_valid,
  output logic [NrEntries-1:0]           set_done,
  output logic [NrEntries-1:0][Xlen-1:0] set_result
);
  // Walk from the highest port down so the lowest index overwrites last.
  always_comb begin
    set_done   = '0;
    set_result = '0;
    for (int i = NrWbPorts - 1; i >= 0; i--) begin
      if (wb_valid[i] && entry_valid[wb_id[i]]) begin
        set_done[wb_id[i]]   = 1'b1;
        set_result[wb_id[i]] = wb_result[i];
      end
    end
  end
endmodule

// File: rtl/rob_commit_window.sv
// In-order retirement buffer: one issue per cycle, multi-port writeback, up to NrCommitPorts retires.
module rob_commit_window
  import rob_pkg::*;
#(
  parameter int unsigned NrEntries     = DefNrEntries,
  parameter int unsigned NrCommitPorts = DefNrCommitPorts,
  parameter int unsigned NrWbPorts     = DefNrWbPorts,
  parameter int unsigned Xlen          = DefXlen,
  parameter int unsigned PayloadWidth  = DefPayloadWidth,
  localparam int unsigned IdW          = rob_id_width(NrEntries),
  localparam int unsigned CntW         = $clog2(NrEntries + 1)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       flush_i,
  input  logic                                       issue_valid_i,
  input  logic [PayloadWidth-1:0]                    issue_payload_i,
  output logic                                       issue_ready_o,
  output logic [IdW-1:0]                             issue_id_o,
  input  logic [NrWbPorts-1:0]                       wb_valid_i,
  input  logic [NrWbPorts-1:0][IdW-1:0]              wb_id_i,
  input  logic [NrWbPorts-1:0][Xlen-1:0]             wb_result_i,
  output logic [NrCommitPorts-1:0]                   commit_valid_o,
  output logic [NrCommitPorts-1:0][PayloadWidth-1:0] commit_payload_o,
  output logic [NrCommitPorts-1:0][Xlen-1:0]         commit_result_o,
  input  logic [NrCommitPorts-1:0]                   commit_ack_i,
  output logic                                       empty_o
);
  typedef struct packed {
    logic                    valid;
    logic                    done;
    logic [PayloadWidth-1:0] payload;
    logic [Xlen-1:0]         result;
  } entry_t;

  entry_t [NrEntries-1:0]           entries;
  logic   [IdW-1:0]                 head, tail;
  logic   [CntW-1:0]                count, retired;
  logic                             fire;
  logic   [NrEntries-1:0]           entry_valid, set_done;
  logic   [NrEntries-1:0][Xlen-1:0] set_result;
  logic   [NrCommitPorts-1:0][IdW-1:0] cptr;
  logic   [NrCommitPorts-1:0]       visible;

  assign issue_ready_o = (count != CntW'(NrEntries));
  assign issue_id_o    = tail;
  assign empty_o       = (count == '0);
  assign fire          = issue_valid_i && issue_ready_o;
  assign retired       = CntW'($countones(commit_ack_i));

  for (genvar e = 0; e < NrEntries; e++) begin : g_ev
    assign entry_valid[e] = entries[e].valid;
  end

  rob_wb_arbiter #(
    .NrEntries(NrEntries), .NrWbPorts(NrWbPorts), .Xlen(Xlen)
  ) u_wb_arb (
    .wb_valid   (wb_valid_i),
    .wb_id      (wb_id_i),
    .wb_result  (wb_result_i),
    .entry_valid(entry_valid),
    .set_done   (set_done),
    .set_result (set_result)
  );

  // Port k only shows a completed entry if every older port does too.
  for (genvar k = 0; k < NrCommitPorts; k++) begin : g_cp
    assign cptr[k]             = head + IdW'(k);
    assign visible[k]          = entries[cptr[k]].valid && entries[cptr[k]].done;
    assign commit_payload_o[k] = entries[cptr[k]].payload;
    assign commit_result_o[k]  = entries[cptr[k]].result;
    if (k == 0) begin : g_first
      assign commit_valid_o[k] = visible[k];
    end else begin : g_rest
      assign commit_valid_o[k] = visible[k] && commit_valid_o[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int e = 0; e < NrEntries; e++) begin
        entries[e].valid <= 1'b0;
        entries[e].done  <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int e = 0; e < NrEntries; e++) begin
        if (set_done[e]) begin
          entries[e].done   <= 1'b1;
          entries[e].result <= set_result[e];
        end
      end
      if (fire) begin
        entries[tail].valid   <= 1'b1;
        entries[tail].done    <= 1'b0;
        entries[tail].payload <= issue_payload_i;
      end
      // Retire clears come last so they win over a late writeback to the same slot.
      for (int k = 0; k < NrCommitPorts; k++) begin
        if (commit_ack_i[k]) begin
          entries[cptr[k]].valid <= 1'b0;
          entries[cptr[k]].done  <= 1'b0;
        end
      end
      head  <= head + IdW'(retired);
      tail  <= tail + IdW'(fire);
      count <= count + CntW'(fire) - retired;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      assert ((commit_ack_i & ~commit_valid_o) == '0);
      assert ((commit_ack_i & (commit_ack_i + NrCommitPorts'(1))) == '0);
    end
  end
endmodule

// File: tb/tb_rob_commit_window.sv
// Directed bench for rob_commit_window with a scoreboard of expected retirements.
module tb_rob_commit_window;
  logic             clk = 1'b0;
  logic             rst, flush, issue_valid;
  logic [63:0]      issue_payload;
  logic             issue_ready;
  logic [2:0]       issue_id;
  logic [3:0]       wb_valid;
  logic [3:0][2:0]  wb_id;
  logic [3:0][63:0] wb_result;
  logic [1:0]       commit_valid, commit_ack;
  logic [1:0][63:0] commit_payload, commit_result;
  logic             empty;

  typedef struct {
    logic [63:0] p;
    logic [63:0] r;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rob_commit_window dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_payload_i(issue_payload),
    .issue_ready_o(issue_ready), .issue_id_o(issue_id),
    .wb_valid_i(wb_valid), .wb_id_i(wb_id), .wb_result_i(wb_result),
    .commit_valid_o(commit_valid), .commit_payload_o(commit_payload),
    .commit_result_o(commit_result), .commit_ack_i(commit_ack),
    .empty_o(empty)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: every retirement handshake is checked against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      for (int k = 0; k < 2; k++) begin
        if (commit_ack[k] && commit_valid[k]) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL retire_unexpected: port %0d payload %0h, none expected", k, commit_payload[k]);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("retire_payload", commit_payload[k], e.p);
            chk("retire_result", commit_result[k], e.r);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_issue(input logic [63:0] p, input logic [63:0] r);
    issue_valid   = 1'b1;
    issue_payload = p;
    chk("issue_ready", {63'd0, issue_ready}, 64'd1);
    if (issue_ready) q.push_back('{p, r});
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic set_wb(input int port, input logic [2:0] id, input logic [63:0] res);
    wb_valid[port]  = 1'b1;
    wb_id[port]     = id;
    wb_result[port] = res;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && !empty; c++) begin
      commit_ack = commit_valid;
      tick();
    end
    commit_ack = '0;
    chk("drain_empty", {63'd0, empty}, 64'd1);
  endtask

  task automatic chk_idle_state(input string nm);
    chk({nm, "_empty"}, {63'd0, empty}, 64'd1);
    chk({nm, "_id"}, {61'd0, issue_id}, 64'd0);
    chk({nm, "_cvalid"}, {62'd0, commit_valid}, 64'd0);
    chk({nm, "_ready"}, {63'd0, issue_ready}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_payload = '0;
    wb_valid = '0; wb_id = '0; wb_result = '0; commit_ack = '0;
    tick();
    do_reset();
    chk_idle_state("reset");

    // Fill to capacity, reject a 9th, then ack-one plus issue while still full.
    for (int i = 0; i < 8; i++) begin
      chk("fill_id", {61'd0, issue_id}, 64'(i));
      do_issue(64'h100 + 64'(i), 64'h200 + 64'(i));
    end
    chk("full_ready", {63'd0, issue_ready}, 64'd0);
    chk("full_empty", {63'd0, empty}, 64'd0);
    issue_valid = 1'b1; issue_payload = 64'hDEAD;
    tick();
    issue_valid = 1'b0;
    chk("reject_ready", {63'd0, issue_ready}, 64'd0);
    chk("reject_id", {61'd0, issue_id}, 64'd0);
    for (int i = 0; i < 4; i++) set_wb(i, 3'(i), 64'h200 + 64'(i));
    tick();
    for (int i = 0; i < 4; i++) set_wb(i, 3'(i + 4), 64'h204 + 64'(i));
    tick();
    wb_valid = '0;
    chk("full_cvalid", {62'd0, commit_valid}, 64'd3);
    commit_ack = 2'b01; issue_valid = 1'b1; issue_payload = 64'hBEEF;
    chk("simul_ready", {63'd0, issue_ready}, 64'd0);
    tick();
    commit_ack = '0; issue_valid = 1'b0;
    chk("after_ack_ready", {63'd0, issue_ready}, 64'd1);
    chk("after_ack_id", {61'd0, issue_id}, 64'd0);
    drain();

    // Dual commit: out-of-order writeback, in-order visibility.
    do_reset();
    for (int i = 0; i < 3; i++) do_issue(64'h300 + 64'(i), 64'h310 + 64'(i));
    set_wb(1, 3'd1, 64'h311);
    tick();
    wb_valid = '0;
    chk("dual_wait", {62'd0, commit_valid}, 64'd0);
    set_wb(0, 3'd0, 64'h310);
    tick();
    wb_valid = '0;
    chk("dual_both", {62'd0, commit_valid}, 64'd3);
    commit_ack = 2'b11;
    tick();
    commit_ack = '0;
    chk("dual_after_cvalid", {62'd0, commit_valid}, 64'd0);
    chk("dual_after_id", {61'd0, issue_id}, 64'd3);
    chk("dual_after_empty", {63'd0, empty}, 64'd0);
    set_wb(2, 3'd2, 64'h312);
    tick();
    wb_valid = '0;
    chk("dual_last", {62'd0, commit_valid}, 64'd1);
    commit_ack = 2'b01;
    tick();
    commit_ack = '0;
    chk("dual_empty", {63'd0, empty}, 64'd1);

    // Wrap-around with a single instruction in flight.
    for (int i = 0; i < 13; i++) begin
      logic [2:0] eid;
      eid = 3'(3 + i);
      chk("wrap_id", {61'd0, issue_id}, {61'd0, eid});
      do_issue(64'h500 + 64'(i), 64'h600 + 64'(i));
      chk("wrap_busy", {63'd0, empty}, 64'd0);
      set_wb(0, eid, 64'h600 + 64'(i));
      tick();
      wb_valid = '0;
      chk("wrap_cvalid", {62'd0, commit_valid}, 64'd1);
      commit_ack = 2'b01;
      tick();
      commit_ack = '0;
      chk("wrap_empty", {63'd0, empty}, 64'd1);
    end

    // Writeback collision and writeback to a dead entry.
    do_reset();
    for (int i = 0; i < 3; i++) do_issue(64'h400 + 64'(i), 64'h410 + 64'(i));
    do_issue(64'h403, 64'hA);
    set_wb(0, 3'd3, 64'hA);
    set_wb(2, 3'd3, 64'hB);
    set_wb(1, 3'd5, 64'hEE);
    tick();
    wb_valid = '0;
    chk("coll_cvalid", {62'd0, commit_valid}, 64'd0);
    chk("coll_id", {61'd0, issue_id}, 64'd4);
    chk("coll_empty", {63'd0, empty}, 64'd0);
    set_wb(0, 3'd0, 64'h410);
    set_wb(1, 3'd1, 64'h411);
    set_wb(3, 3'd2, 64'h412);
    tick();
    wb_valid = '0;
    chk("coll_ready2", {62'd0, commit_valid}, 64'd3);
    drain();

    // Flush with issue and ack asserted in the same cycle.
    for (int i = 0; i < 5; i++) do_issue(64'h700 + 64'(i), 64'h710 + 64'(i));
    set_wb(0, 3'd4, 64'h710);
    set_wb(1, 3'd5, 64'h711);
    tick();
    wb_valid = '0;
    chk("pre_flush_cvalid", {62'd0, commit_valid}, 64'd3);
    flush = 1'b1; issue_valid = 1'b1; issue_payload = 64'h777; commit_ack = 2'b11;
    q.delete();
    tick();
    flush = 1'b0; issue_valid = 1'b0; commit_ack = '0;
    chk_idle_state("flush");

    // Reset mid-stream with issue and ack asserted.
    for (int i = 0; i < 3; i++) do_issue(64'h800 + 64'(i), 64'h810 + 64'(i));
    set_wb(0, 3'd0, 64'h810);
    tick();
    wb_valid = '0;
    chk("pre_rst_cvalid", {62'd0, commit_valid}, 64'd1);
    rst = 1'b1; issue_valid = 1'b1; issue_payload = 64'h888; commit_ack = 2'b01;
    q.delete();
    tick();
    rst = 1'b0; issue_valid = 1'b0; commit_ack = '0;
    chk_idle_state("midrst");

    do_issue(64'h900, 64'h901);
    set_wb(3, 3'd0, 64'h901);
    tick();
    wb_valid = '0;
    drain();
    chk("scoreboard_left", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
